// File: rtl/remap_fetch_pkg.sv
// Shared types and field widths for the remap fetch engine.
//   state_t  : fetch FSM states
//   fields_t : requantisation fields carried alongside a fetch
package remap_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int M1_W     = 26;
  localparam int N1_W     = 6;
  localparam int NEG_XZ_W = 9;
  localparam int YZ_W     = 8;

  typedef struct packed {
    logic [M1_W-1:0]     m1;
    logic [N1_W-1:0]     n1;
    logic [NEG_XZ_W-1:0] neg_xz;
    logic [YZ_W-1:0]     yz;
  } fields_t;

endpackage

// File: rtl/remap_fetch_fifo.sv
// Synchronous FIFO holding returned RTM beats until the consumer takes them.
//   push/push_data : write one entry (accepted when not full, or when popping)
//   pop/pop_data   : pop_data shows the head; pop is ignored while empty
//   full/empty/count : occupancy status
module remap_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO can still take a write in the same cycle it gives one up.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == (PW+1)'(DEPTH));
  assign pop_data = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/remap_fetch.sv
// Remap fetch engine: walks a strided set of RTM row segments, issues one
// credit-limited read per cycle on a broadcast read port, buffers returned
// beats and streams them out with valid/ready alongside latched
// requantisation fields.
//   clk, rst                       : clock, synchronous active-high reset
//   start_pulse + X_addr/len_minus_1/stride/seg_minus_1 : operation request
//   m1/n1/neg_Xz/Yz                : fields latched on an accepted start
//   rtm_rd_*                       : registered read request to the RTM slices
//   rtm_dout*                      : RTM read return, RD_LAT after the request
//   ppus_Xs*                       : output beat stream (valid/ready)
//   ppus_m1/n1/neg_Xz/Yz           : latched fields, OUT_PIPE stages late
//   busy, done                     : operation in progress / one-cycle completion
module remap_fetch
  import remap_fetch_pkg::*;
#(
  parameter int S          = 8,
  parameter int R          = 16,
  parameter int RTM_DEPTH  = 4096,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int OUT_PIPE   = 0,
  localparam int AW = $clog2(RTM_DEPTH),
  localparam int XW = S*R*8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_pulse,
  input  logic [AW-1:0]              X_addr,
  input  logic [AW-1:0]              len_minus_1,
  input  logic [AW-1:0]              stride,
  input  logic [7:0]                 seg_minus_1,
  input  logic [M1_W-1:0]            m1,
  input  logic [N1_W-1:0]            n1,
  input  logic signed [NEG_XZ_W-1:0] neg_Xz,
  input  logic [YZ_W-1:0]            Yz,
  output logic                       rtm_rd_vld,
  output logic                       rtm_rd_last,
  output logic [S-1:0]               rtm_rd_en,
  output logic [S*AW-1:0]            rtm_rd_addr,
  input  logic [XW-1:0]              rtm_dout,
  input  logic                       rtm_dout_vld,
  input  logic                       rtm_dout_last,
  output logic [XW-1:0]              ppus_Xs,
  output logic                       ppus_Xs_vld,
  input  logic                       ppus_Xs_rdy,
  output logic                       ppus_Xs_last,
  output logic [M1_W-1:0]            ppus_m1,
  output logic [N1_W-1:0]            ppus_n1,
  output logic signed [NEG_XZ_W-1:0] ppus_neg_Xz,
  output logic [YZ_W-1:0]            ppus_Yz,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(RD_LAT + 1);

  state_t        state, state_nxt;
  fields_t       fld_q, fld_out;
  logic [AW-1:0] seg_base, row_cnt, len_q, stride_q;
  logic [7:0]    seg_cnt, seg_m1_q;
  logic [CW-1:0] in_flight;
  logic [DW-1:0] disc_cnt;
  logic          rd_vld_q, rd_last_q;
  logic [AW-1:0] rd_addr_q;
  logic          done_q;

  logic          accept, issue, credit_ok, row_end, final_rd, beat_ok, pop;
  logic [AW-1:0] c_base, c_row, c_len, c_stride, c_addr;
  logic [7:0]    c_seg, c_segm;
  logic [XW:0]   fifo_head;
  logic          fifo_full, fifo_empty, head_last;
  logic [CW-1:0] fifo_count;

  assign accept = (state == IDLE) && start_pulse;

  // In the start cycle the walk runs directly off the request inputs so the
  // first read issues without waiting for the latched copies.
  always_comb begin
    c_base   = seg_base;
    c_row    = row_cnt;
    c_seg    = seg_cnt;
    c_len    = len_q;
    c_segm   = seg_m1_q;
    c_stride = stride_q;
    if (state == IDLE) begin
      c_base   = X_addr;
      c_row    = '0;
      c_seg    = '0;
      c_len    = len_minus_1;
      c_segm   = seg_minus_1;
      c_stride = stride;
    end
  end

  // Address width equals clog2(RTM_DEPTH), so the adder wraps mod RTM_DEPTH.
  assign c_addr    = c_base + c_row;
  assign row_end   = (c_row == c_len);
  assign final_rd  = row_end && (c_seg == c_segm);
  // Count reads from the issue decision so a returning beat always has a slot.
  assign credit_ok = (({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH)) && !fifo_full;
  assign issue     = (accept || (state == RD)) && credit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_base <= '0;
      row_cnt  <= '0;
      seg_cnt  <= '0;
      len_q    <= '0;
      stride_q <= '0;
      seg_m1_q <= '0;
      fld_q    <= '0;
    end else begin
      if (accept) begin
        len_q    <= len_minus_1;
        stride_q <= stride;
        seg_m1_q <= seg_minus_1;
        fld_q    <= {m1, n1, neg_Xz, Yz};
      end
      if (issue) begin
        if (row_end) begin
          row_cnt  <= '0;
          seg_cnt  <= c_seg + 8'd1;
          seg_base <= c_base + c_stride;
        end else begin
          row_cnt  <= c_row + AW'(1);
          seg_cnt  <= c_seg;
          seg_base <= c_base;
        end
      end else if (accept) begin
        row_cnt  <= '0;
        seg_cnt  <= '0;
        seg_base <= X_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= issue && final_rd;
      if (issue) rd_addr_q <= c_addr;
    end
  end

  assign rtm_rd_vld  = rd_vld_q;
  assign rtm_rd_last = rd_last_q;
  assign rtm_rd_en   = {S{rd_vld_q}};
  assign rtm_rd_addr = {S{rd_addr_q}};

  // Returns from reads issued before a reset can still arrive for RD_LAT
  // cycles afterwards; those, and any beat with nothing outstanding, are dropped.
  assign beat_ok = rtm_dout_vld && (disc_cnt == '0) && (in_flight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
      disc_cnt  <= DW'(RD_LAT);
    end else begin
      in_flight <= in_flight + CW'(issue) - CW'(beat_ok);
      if (disc_cnt != '0) disc_cnt <= disc_cnt - DW'(1);
    end
  end

  remap_fetch_fifo #(
    .WIDTH (XW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (beat_ok),
    .push_data ({rtm_dout_last, rtm_dout}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_last    = fifo_head[XW];
  assign ppus_Xs_vld  = !fifo_empty;
  assign pop          = ppus_Xs_vld && ppus_Xs_rdy;
  assign ppus_Xs      = ppus_Xs_vld ? fifo_head[XW-1:0] : '0;
  assign ppus_Xs_last = ppus_Xs_vld && head_last;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (issue && final_rd) ? DRAIN : RD;
      RD:      if (issue && final_rd) state_nxt = DRAIN;
      DRAIN:   if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RD) || (state == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state == DRAIN) && pop && head_last;
  end

  assign done = done_q;

  if (OUT_PIPE == 0) begin : g_nopipe
    assign fld_out = fld_q;
  end else begin : g_pipe
    fields_t pipe_q [OUT_PIPE];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < OUT_PIPE; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= fld_q;
        for (int i = 1; i < OUT_PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign fld_out = pipe_q[OUT_PIPE-1];
  end

  assign ppus_m1     = fld_out.m1;
  assign ppus_n1     = fld_out.n1;
  assign ppus_neg_Xz = fld_out.neg_xz;
  assign ppus_Yz     = fld_out.yz;

endmodule

// File: tb/tb_remap_fetch.sv
module tb_remap_fetch;

  localparam int S = 8, R = 16, RTM_DEPTH = 4096, RD_LAT = 2, FIFO_DEPTH = 8;
  localparam int AW = 12, XW = S*R*8;

  logic clk, rst, start_pulse;
  logic [AW-1:0] X_addr, len_minus_1, stride;
  logic [7:0] seg_minus_1;
  logic [25:0] m1;
  logic [5:0] n1;
  logic signed [8:0] neg_Xz;
  logic [7:0] Yz;
  logic rtm_rd_vld, rtm_rd_last;
  logic [S-1:0] rtm_rd_en;
  logic [S*AW-1:0] rtm_rd_addr;
  logic [XW-1:0] rtm_dout;
  logic rtm_dout_vld, rtm_dout_last;
  logic [XW-1:0] ppus_Xs;
  logic ppus_Xs_vld, ppus_Xs_rdy, ppus_Xs_last;
  logic [25:0] ppus_m1;
  logic [5:0] ppus_n1;
  logic signed [8:0] ppus_neg_Xz;
  logic [7:0] ppus_Yz;
  logic busy, done;

  remap_fetch dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .X_addr(X_addr),
    .len_minus_1(len_minus_1), .stride(stride), .seg_minus_1(seg_minus_1),
    .m1(m1), .n1(n1), .neg_Xz(neg_Xz), .Yz(Yz),
    .rtm_rd_vld(rtm_rd_vld), .rtm_rd_last(rtm_rd_last), .rtm_rd_en(rtm_rd_en),
    .rtm_rd_addr(rtm_rd_addr), .rtm_dout(rtm_dout), .rtm_dout_vld(rtm_dout_vld),
    .rtm_dout_last(rtm_dout_last), .ppus_Xs(ppus_Xs), .ppus_Xs_vld(ppus_Xs_vld),
    .ppus_Xs_rdy(ppus_Xs_rdy), .ppus_Xs_last(ppus_Xs_last), .ppus_m1(ppus_m1),
    .ppus_n1(ppus_n1), .ppus_neg_Xz(ppus_neg_Xz), .ppus_Yz(ppus_Yz),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int x, len, stride, seg;
    int m1, n1, nxz, yz;
    int mode, inject, exp_reads, exp_last;
  } vec_t;
  typedef struct { logic [AW-1:0] addr; logic last; } rd_exp_t;
  typedef struct { logic [XW-1:0] data; logic last; } beat_exp_t;

  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0;
  int rd_seen, popped, rdy_mode, cur_mode;
  bit mon_en = 0, done_exp, op_complete, first_vld_seen;
  logic [AW-1:0] last_rd_addr;
  rd_exp_t exp_rd_q[$];
  beat_exp_t exp_beat_q[$];
  rd_exp_t re;
  beat_exp_t be;
  bit ok;

  function automatic logic [XW-1:0] beat_data(input logic [AW-1:0] a);
    logic [XW-1:0] d;
    for (int i = 0; i < XW/32; i++) d[i*32 +: 32] = {4'hA, a, 16'(i*97) ^ {4'h0, a}};
    return d;
  endfunction

  task automatic chk(input bit good, input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // RTM model: fixed RD_LAT return latency, contents a function of address
  logic [RD_LAT-1:0] p_vld, p_last;
  logic [AW-1:0] p_addr [RD_LAT];
  always @(posedge clk) begin
    p_vld[0]  <= rtm_rd_vld;
    p_last[0] <= rtm_rd_last;
    p_addr[0] <= rtm_rd_addr[AW-1:0];
    for (int i = 1; i < RD_LAT; i++) begin
      p_vld[i]  <= p_vld[i-1];
      p_last[i] <= p_last[i-1];
      p_addr[i] <= p_addr[i-1];
    end
  end
  assign rtm_dout_vld  = p_vld[RD_LAT-1];
  assign rtm_dout_last = p_last[RD_LAT-1];
  assign rtm_dout      = beat_data(p_addr[RD_LAT-1]);

  always @(posedge clk) cyc <= cyc + 1;

  // consumer ready: 0 = always, 1 = one high then three low, 2 = random
  initial begin
    int ph = 0;
    ppus_Xs_rdy = 1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       begin ppus_Xs_rdy = (ph == 0); ph = (ph + 1) % 4; end
        2:       ppus_Xs_rdy = 1'($urandom_range(0, 1));
        default: ppus_Xs_rdy = 1;
      endcase
    end
  end

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (rtm_rd_vld) begin
        rd_seen++;
        if (rtm_rd_last) last_rd_addr = rtm_rd_addr[AW-1:0];
        if (exp_rd_q.size() == 0) chk(0, "rd_extra", 64'(rtm_rd_addr[AW-1:0]), 0);
        else begin
          re = exp_rd_q.pop_front();
          ok = 1;
          for (int s = 0; s < S; s++) if (rtm_rd_addr[s*AW +: AW] != re.addr) ok = 0;
          chk(ok, "rd_addr", 64'(rtm_rd_addr[AW-1:0]), 64'(re.addr));
          chk(rtm_rd_en == '1, "rd_en", 64'(rtm_rd_en), 64'hff);
          chk(rtm_rd_last == re.last, "rd_last", 64'(rtm_rd_last), 64'(re.last));
        end
      end
      if (busy) chk((rd_seen - popped) <= FIFO_DEPTH, "credit", 64'(rd_seen - popped), FIFO_DEPTH);
      if (done || done_exp) chk(done == done_exp, "done", 64'(done), 64'(done_exp));
      if (done) op_complete = 1;
      done_exp = 0;
      if (ppus_Xs_vld) begin
        if (!first_vld_seen) begin
          first_vld_seen = 1;
          if (cur_mode == 0) chk(cyc - start_cyc == RD_LAT + 2, "latency", 64'(cyc - start_cyc), RD_LAT + 2);
        end
        if (exp_beat_q.size() == 0) chk(0, "beat_extra", ppus_Xs[63:0], 0);
        else begin
          be = exp_beat_q[0];
          chk(ppus_Xs == be.data, "beat_data", ppus_Xs[63:0], be.data[63:0]);
          chk(ppus_Xs_last == be.last, "beat_last", 64'(ppus_Xs_last), 64'(be.last));
          if (ppus_Xs_rdy) begin
            void'(exp_beat_q.pop_front());
            popped++;
            if (be.last) done_exp = 1;
          end
        end
      end
    end
  end

  task automatic build_exp(input vec_t v);
    logic [AW-1:0] a;
    logic lst;
    exp_rd_q.delete();
    exp_beat_q.delete();
    for (int k = 0; k <= v.seg; k++)
      for (int j = 0; j <= v.len; j++) begin
        a = AW'((v.x + k*v.stride + j) % RTM_DEPTH);
        lst = (k == v.seg) && (j == v.len);
        exp_rd_q.push_back('{addr: a, last: lst});
        exp_beat_q.push_back('{data: beat_data(a), last: lst});
      end
    rd_seen = 0; popped = 0; done_exp = 0; op_complete = 0;
    last_rd_addr = '0; first_vld_seen = 0;
    cur_mode = v.mode; rdy_mode = v.mode;
    mon_en = 1;
  endtask

  task automatic start_op(input vec_t v);
    @(posedge clk);
    #1;
    X_addr = AW'(v.x); len_minus_1 = AW'(v.len); stride = AW'(v.stride);
    seg_minus_1 = 8'(v.seg); m1 = 26'(v.m1); n1 = 6'(v.n1);
    neg_Xz = 9'(v.nxz); Yz = 8'(v.yz);
    start_pulse = 1; start_cyc = cyc;
    @(posedge clk);
    #1;
    start_pulse = 0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int cnt = 0;
    build_exp(v);
    start_op(v);
    while (!op_complete && cnt < 2000) begin
      if (v.inject != 0 && cnt == v.inject) begin
        X_addr = 999; len_minus_1 = 0; stride = 5; seg_minus_1 = 0;
        m1 = 0; n1 = 0; neg_Xz = 0; Yz = 0; start_pulse = 1;
      end else start_pulse = 0;
      @(posedge clk);
      #1;
      cnt++;
    end
    start_pulse = 0;
    chk(op_complete, {tag, "_timeout"}, 64'(cnt), 0);
    @(negedge clk);
    chk(exp_rd_q.size() == 0 && exp_beat_q.size() == 0, {tag, "_leftover"},
        64'(exp_rd_q.size() + exp_beat_q.size()), 0);
    chk(rd_seen == v.exp_reads, {tag, "_reads"}, 64'(rd_seen), 64'(v.exp_reads));
    chk(last_rd_addr == AW'(v.exp_last), {tag, "_last_addr"}, 64'(last_rd_addr), 64'(v.exp_last));
    chk(ppus_m1 == 26'(v.m1), {tag, "_m1"}, 64'(ppus_m1), 64'(26'(v.m1)));
    chk(ppus_n1 == 6'(v.n1), {tag, "_n1"}, 64'(ppus_n1), 64'(6'(v.n1)));
    chk(ppus_neg_Xz == 9'(v.nxz), {tag, "_neg_xz"}, 64'(ppus_neg_Xz), 64'(9'(v.nxz)));
    chk(ppus_Yz == 8'(v.yz), {tag, "_yz"}, 64'(ppus_Yz), 64'(8'(v.yz)));
    chk(!busy && !done, {tag, "_idle_after"}, 64'({busy, done}), 0);
  endtask

  task automatic check_zero(input string tag);
    chk(!rtm_rd_vld && !rtm_rd_last && rtm_rd_en == 0 && rtm_rd_addr == 0, {tag, "_rd_port"},
        64'({rtm_rd_vld, rtm_rd_last, rtm_rd_en}), 0);
    chk(!ppus_Xs_vld && !ppus_Xs_last && ppus_Xs == 0, {tag, "_xs"}, 64'({ppus_Xs_vld, ppus_Xs_last}), 0);
    chk(ppus_m1 == 0 && ppus_n1 == 0 && ppus_neg_Xz == 0 && ppus_Yz == 0, {tag, "_fields"},
        64'(ppus_m1), 0);
    chk(!busy && !done, {tag, "_status"}, 64'({busy, done}), 0);
  endtask

  vec_t vecs [7];

  initial begin
    int cnt;
    vec_t rv;
    vecs[0] = '{10,   3,  0,  0, 'h1234567,  5,   -3, 'h11, 0, 0,  4,  13};
    vecs[1] = '{0,    1, 16,  2, 'h0ABCDEF, 63,  255, 'h80, 0, 0,  6,  33};
    vecs[2] = '{4094, 3,  0,  0, 'h3FFFFFF,  1, -256, 'hFF, 0, 0,  4,   1};
    vecs[3] = '{100, 31,  0,  0, 'h2000001, 17,   12, 'h42, 1, 0, 32, 131};
    vecs[4] = '{4000, 2, 50,  3, 'h0000010, 33,  -77, 'h05, 2, 0, 12,  56};
    vecs[5] = '{7,    0,  0,  0, 'h1555555, 42,  100, 'hA5, 0, 0,  1,   7};
    vecs[6] = '{200, 15,  0,  0, 'h0FEDCBA,  9,   -1, 'h3C, 0, 3, 16, 215};
    rv      = '{300, 15,  0,  0, 'h1111111, 22,   33, 'h44, 0, 0, 16, 315};

    rst = 1; start_pulse = 0; X_addr = 0; len_minus_1 = 0; stride = 0;
    seg_minus_1 = 0; m1 = 0; n1 = 0; neg_Xz = 0; Yz = 0; rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // reset after the fifth beat has been taken
    build_exp(rv);
    start_op(rv);
    cnt = 0;
    while (popped < 5 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(popped == 5, "rst_mid_reach", 64'(popped), 5);
    rst = 1;
    mon_en = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_zero("rst_mid");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk(!done && !ppus_Xs_vld && !busy, "rst_quiet", 64'({done, ppus_Xs_vld, busy}), 0);
    end
    run_op(vecs[1], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
